// File: rtl/waveform_analyzer_if.sv
// Sample-stream and measurement-result bundle for waveform_analyzer.
// Signals:
//   en_i, sample_i, sample_valid_i     : control and sample stream into the analyzer
//   period_o, high_cnt_o, max_o, min_o : latched per-period measurement
//   meas_valid_o, timeout_o            : one-cycle event pulses
// Modports: slave = analyzer side, master = source/consumer side.
interface waveform_analyzer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 24
);
  logic                         en_i;
  logic signed [DATA_WIDTH-1:0] sample_i;
  logic                         sample_valid_i;
  logic [CNT_WIDTH-1:0]         period_o;
  logic [CNT_WIDTH-1:0]         high_cnt_o;
  logic signed [DATA_WIDTH-1:0] max_o;
  logic signed [DATA_WIDTH-1:0] min_o;
  logic                         meas_valid_o;
  logic                         timeout_o;

  modport slave (
    input  en_i, sample_i, sample_valid_i,
    output period_o, high_cnt_o, max_o, min_o, meas_valid_o, timeout_o
  );

  modport master (
    output en_i, sample_i, sample_valid_i,
    input  period_o, high_cnt_o, max_o, min_o, meas_valid_o, timeout_o
  );
endinterface

// File: rtl/waveform_analyzer.sv
// Measures one full period of a signed sample stream at a time: period length,
// high time, maximum and minimum. Edges come from a Schmitt trigger around zero.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : waveform_analyzer_if.slave (enable, sample stream, measurement outputs)
module waveform_analyzer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 24,
  parameter int          HYST       = 4
) (
  input  logic               clk,
  input  logic               rst,
  waveform_analyzer_if.slave bus
);

  localparam logic signed [DATA_WIDTH-1:0] HI_TH   = DATA_WIDTH'(HYST);
  localparam logic signed [DATA_WIDTH-1:0] LO_TH   = DATA_WIDTH'(-HYST);
  localparam logic [CNT_WIDTH-1:0]         CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]         CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {ARM, WAIT_EDGE, MEASURE} state_t;

  state_t                       state, state_n;
  logic                         level, level_n;
  logic [CNT_WIDTH-1:0]         cnt, cnt_n, high, high_n;
  logic signed [DATA_WIDTH-1:0] run_max, run_max_n, run_min, run_min_n;
  logic [CNT_WIDTH-1:0]         out_period, out_period_n, out_high, out_high_n;
  logic signed [DATA_WIDTH-1:0] out_max, out_max_n, out_min, out_min_n;
  logic                         meas_pulse, meas_pulse_n, tmo_pulse, tmo_pulse_n;

  logic                         above, below, lvl_next, rise;
  logic signed [DATA_WIDTH-1:0] sample;

  assign sample   = bus.sample_i;
  assign above    = (sample >= HI_TH);
  assign below    = (sample <= LO_TH);
  assign lvl_next = above ? 1'b1 : (below ? 1'b0 : level);
  assign rise     = bus.sample_valid_i && !level && above;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARM;
      level      <= 1'b0;
      cnt        <= '0;
      high       <= '0;
      run_max    <= '0;
      run_min    <= '0;
      out_period <= '0;
      out_high   <= '0;
      out_max    <= '0;
      out_min    <= '0;
      meas_pulse <= 1'b0;
      tmo_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      cnt        <= cnt_n;
      high       <= high_n;
      run_max    <= run_max_n;
      run_min    <= run_min_n;
      out_period <= out_period_n;
      out_high   <= out_high_n;
      out_max    <= out_max_n;
      out_min    <= out_min_n;
      meas_pulse <= meas_pulse_n;
      tmo_pulse  <= tmo_pulse_n;
    end
  end

  // Next-state and datapath update; only valid samples advance anything
  always_comb begin
    state_n      = state;
    level_n      = level;
    cnt_n        = cnt;
    high_n       = high;
    run_max_n    = run_max;
    run_min_n    = run_min;
    out_period_n = out_period;
    out_high_n   = out_high;
    out_max_n    = out_max;
    out_min_n    = out_min;
    meas_pulse_n = 1'b0;
    tmo_pulse_n  = 1'b0;

    if (!bus.en_i) begin
      state_n   = ARM;
      cnt_n     = '0;
      high_n    = '0;
      run_max_n = '0;
      run_min_n = '0;
    end else if (bus.sample_valid_i) begin
      level_n = lvl_next;
      unique case (state)
        ARM: begin
          // Arming on a low sample discards the partial first period
          if (below) state_n = WAIT_EDGE;
        end
        WAIT_EDGE, MEASURE: begin
          if (rise) begin
            if (state == MEASURE) begin
              out_period_n = cnt;
              out_high_n   = high;
              out_max_n    = run_max;
              out_min_n    = run_min;
              meas_pulse_n = 1'b1;
            end
            // Rise sample opens the next period
            state_n   = MEASURE;
            cnt_n     = CNT_ONE;
            high_n    = CNT_ONE;
            run_max_n = sample;
            run_min_n = sample;
          end else if (cnt == CNT_MAX) begin
            // Saturated without a rise: abandon rather than wrap
            tmo_pulse_n = 1'b1;
            state_n     = ARM;
            cnt_n       = '0;
            high_n      = '0;
            run_max_n   = '0;
            run_min_n   = '0;
          end else if (state == MEASURE) begin
            cnt_n  = cnt + CNT_ONE;
            high_n = high + CNT_WIDTH'(lvl_next);
            if (sample > run_max) run_max_n = sample;
            if (sample < run_min) run_min_n = sample;
          end
        end
        default: state_n = ARM;
      endcase
    end
  end

  assign bus.period_o     = out_period;
  assign bus.high_cnt_o   = out_high;
  assign bus.max_o        = out_max;
  assign bus.min_o        = out_min;
  assign bus.meas_valid_o = meas_pulse;
  assign bus.timeout_o    = tmo_pulse;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Scoreboard bench for waveform_analyzer: expected measurements and timeouts are
// queued as stimulus is driven and compared when the analyzer pulses.
module tb_waveform_analyzer;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int          HY = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  waveform_analyzer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  waveform_analyzer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .HYST(HY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit tmo;
    int period;
    int high;
    int mx;
    int mn;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   last_meas = 0;
  int   exp_gap   = 0;
  int   sine_tab[16] = '{0, 38, 71, 92, 100, 92, 71, 38,
                         0, -38, -71, -92, -100, -92, -71, -38};

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.meas_valid_o && bus.timeout_o) chk("excl", 1, 0);
    if (bus.meas_valid_o || bus.timeout_o) begin
      if (sb.size() == 0) begin
        chk(bus.timeout_o ? "unexp_tmo" : "unexp_meas", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("kind", int'(bus.timeout_o), int'(e.tmo));
        if (!e.tmo && bus.meas_valid_o) begin
          chk("period", int'(bus.period_o), e.period);
          chk("high",   int'(bus.high_cnt_o), e.high);
          chk("max",    int'(bus.max_o), e.mx);
          chk("min",    int'(bus.min_o), e.mn);
          if (exp_gap != 0 && last_meas != 0) chk("gap", cyc - last_meas, exp_gap);
          last_meas = cyc;
        end
      end
    end
  end

  // One clock per call; returns just after the falling edge so outputs are settled
  task automatic send(input int s, input bit v);
    bus.sample_i       = DW'(s);
    bus.sample_valid_i = v;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic phase(input int n, input int amp, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send(amp, 1'b1);
      if (gaps) send(int'($urandom_range(0, 255)) - 128, 1'b0);
    end
  endtask

  task automatic push_meas(input int p, input int h, input int mx, input int mn, input int n);
    exp_t e;
    e.tmo = 1'b0; e.period = p; e.high = h; e.mx = mx; e.mn = mn;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic push_tmo();
    exp_t e;
    e.tmo = 1'b1; e.period = 0; e.high = 0; e.mx = 0; e.mn = 0;
    sb.push_back(e);
  endtask

  task automatic disarm();
    bus.en_i = 1'b0;
    send(0, 1'b0);
    bus.en_i = 1'b1;
  endtask

  task automatic new_test(input int gap);
    exp_gap   = gap;
    last_meas = 0;
  endtask

  initial begin
    int duty[6];
    duty = '{7, 7, 7, 15, 15, 15};
    rst                = 1'b1;
    bus.en_i           = 1'b1;
    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    send(100, 1'b1);
    chk("rst_period", int'(bus.period_o), 0);
    chk("rst_high",   int'(bus.high_cnt_o), 0);
    chk("rst_max",    int'(bus.max_o), 0);
    chk("rst_min",    int'(bus.min_o), 0);
    chk("rst_meas",   int'(bus.meas_valid_o), 0);
    chk("rst_tmo",    int'(bus.timeout_o), 0);
    rst = 1'b0;

    // Square wave 10/10
    new_test(20);
    push_meas(20, 10, 100, -100, 3);
    repeat (5) begin phase(10, 100, 1'b0); phase(10, -100, 1'b0); end
    chk("sq_done", sb.size(), 0);

    // Disabled: outputs hold, no pulses
    new_test(0);
    bus.en_i = 1'b0;
    phase(10, 100, 1'b0); phase(3, -100, 1'b0); phase(2, 100, 1'b0);
    bus.en_i = 1'b1;
    chk("en_hold_period", int'(bus.period_o), 20);
    chk("en_hold_high",   int'(bus.high_cnt_o), 10);
    chk("en_hold_max",    int'(bus.max_o), 100);

    // Duty cycle 7/13 then 15/5
    disarm();
    new_test(20);
    push_meas(20, 7, 50, -50, 3);
    push_meas(20, 15, 50, -50, 3);
    phase(1, -50, 1'b0);
    foreach (duty[i]) begin phase(duty[i], 50, 1'b0); phase(20 - duty[i], -50, 1'b0); end
    phase(1, 50, 1'b0);
    chk("duty_done", sb.size(), 0);

    // Thresholds exactly at +/-HYST
    disarm();
    new_test(20);
    push_meas(20, 10, HY, -HY, 2);
    phase(1, -HY, 1'b0);
    repeat (2) begin phase(10, HY, 1'b0); phase(10, -HY, 1'b0); end
    phase(1, HY, 1'b0);
    chk("hyst_done", sb.size(), 0);

    // Sub-threshold noise in the low phase
    disarm();
    new_test(20);
    push_meas(20, 10, 100, -100, 3);
    phase(1, -100, 1'b0);
    repeat (3) begin
      phase(10, 100, 1'b0);
      send(-100, 1'b1);
      repeat (4) begin send(HY - 1, 1'b1); send(-(HY - 1), 1'b1); end
      send(-100, 1'b1);
    end
    phase(1, 100, 1'b0);
    chk("noise_done", sb.size(), 0);

    // Valid every other clock
    disarm();
    new_test(40);
    push_meas(20, 10, 100, -100, 3);
    phase(1, -100, 1'b1);
    repeat (3) begin phase(10, 100, 1'b1); phase(10, -100, 1'b1); end
    phase(1, 100, 1'b1);
    chk("gaps_done", sb.size(), 0);

    // Timeout on a frozen high level
    disarm();
    new_test(0);
    phase(1, -100, 1'b0);
    phase(1, 100, 1'b0);
    phase(254, 100, 1'b0);
    push_tmo();
    phase(1, 100, 1'b0);
    phase(20, 100, 1'b0);
    chk("tmo_done", sb.size(), 0);
    chk("tmo_hold_period", int'(bus.period_o), 20);
    chk("tmo_hold_high",   int'(bus.high_cnt_o), 10);
    // Recovery needs arming plus two rises
    phase(10, -100, 1'b0);
    phase(10, 100, 1'b0);
    phase(10, -100, 1'b0);
    push_meas(20, 10, 100, -100, 1);
    phase(1, 100, 1'b0);
    chk("recov_done", sb.size(), 0);

    // Reset coinciding with a rise in MEASURE
    phase(9, 100, 1'b0);
    phase(10, -100, 1'b0);
    rst = 1'b1;
    send(100, 1'b1);
    rst = 1'b0;
    chk("rr_period", int'(bus.period_o), 0);
    chk("rr_high",   int'(bus.high_cnt_o), 0);
    chk("rr_max",    int'(bus.max_o), 0);
    chk("rr_min",    int'(bus.min_o), 0);
    chk("rr_meas",   int'(bus.meas_valid_o), 0);
    chk("rr_tmo",    int'(bus.timeout_o), 0);

    // Sine after reset: arm on a low sample, then two rises per measurement
    new_test(16);
    push_meas(16, 8, 100, -100, 2);
    repeat (4) foreach (sine_tab[k]) send(sine_tab[k], 1'b1);
    phase(4, 0, 1'b0);
    chk("sine_done", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
